// File: rtl/maxpool2x2_sched.sv
// rtl/maxpool2x2_sched.sv - 2x2/stride-2 max-pool scheduler driving one shared external comparator
// Horizontal pair max per odd column; even rows park it in a half-width line buffer, odd rows reduce against it.
module maxpool2x2_sched #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  input  logic [DATA_W-1:0] cmp_y
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW    = (CW > 1) ? CW - 1 : 1;
  localparam int NPAIR = IMG_W / 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVEN  = 2'd1;
  localparam logic [1:0] S_ODD   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] vreg_q, vreg_d;
  logic              pend_q, pend_d;
  logic [PW-1:0]     colp_q, colp_d;
  logic              lastp_q, lastp_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] linebuf_q [NPAIR];

  logic          out_stall;
  logic          accept;
  logic          odd_acc;
  logic          col_end;
  logic          row_end;
  logic          pend_fire;
  logic [PW-1:0] pair_idx;

  assign out_stall = out_valid_q && !out_ready;
  assign in_ready  = ((state_q == S_EVEN) || (state_q == S_ODD)) && !out_stall;
  assign accept    = in_valid && in_ready;
  assign odd_acc   = accept && col_q[0];
  assign col_end   = (col_q == CW'(IMG_W - 1));
  assign row_end   = (row_q == RW'(IMG_H - 1));
  // A held output blocks the vertical compare too, so a stalled result is never overwritten.
  assign pend_fire = pend_q && !out_stall;
  assign pair_idx  = PW'(col_q >> 1);

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  // Pending vertical compare and an odd-column accept cannot overlap: in_ready is low while pend stalls.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    if (pend_q) begin
      cmp_a = vreg_q;
      cmp_b = linebuf_q[colp_q];
    end else if (odd_acc) begin
      cmp_a = in_data;
      cmp_b = hold_q;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EVEN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_EVEN, S_ODD: begin
        if (accept) begin
          col_d = col_end ? '0 : col_q + CW'(1);
          if (col_end) begin
            row_d = row_end ? '0 : row_q + RW'(1);
            if (state_q == S_EVEN) begin
              state_d = S_ODD;
            end else begin
              state_d = row_end ? S_DRAIN : S_EVEN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_last_q && out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done_d = (state_q == S_DRAIN) && (state_d == S_IDLE);

  always_comb begin
    hold_d  = hold_q;
    vreg_d  = vreg_q;
    pend_d  = pend_q;
    colp_d  = colp_q;
    lastp_d = lastp_q;
    if (accept && !col_q[0]) begin
      hold_d = in_data;
    end
    if (odd_acc && (state_q == S_ODD)) begin
      vreg_d  = cmp_y;
      pend_d  = 1'b1;
      colp_d  = pair_idx;
      lastp_d = col_end && row_end;
    end else if (pend_fire) begin
      pend_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (pend_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = cmp_y;
      out_last_d  = lastp_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      vreg_q      <= '0;
      pend_q      <= 1'b0;
      colp_q      <= '0;
      lastp_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      vreg_q      <= vreg_d;
      pend_q      <= pend_d;
      colp_q      <= colp_d;
      lastp_q     <= lastp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Line buffer holds even-row pair maxima; its contents are don't-care until written each frame.
  always_ff @(posedge clk) begin
    if (odd_acc && (state_q == S_EVEN)) begin
      linebuf_q[pair_idx] <= cmp_y;
    end
  end

endmodule

// File: tb/tb_maxpool2x2_sched.sv
// tb/tb_maxpool2x2_sched.sv - self-checking bench for maxpool2x2_sched (4x4 and 24x24 instances)
module tb_maxpool2x2_sched;
  localparam int DW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, in_valid, out_ready, sel;
  logic [DW-1:0] in_data;

  logic          s_busy, s_done, s_in_ready, s_out_valid, s_out_last;
  logic [DW-1:0] s_out_data, s_cmp_a, s_cmp_b, s_cmp_y;
  logic          b_busy, b_done, b_in_ready, b_out_valid, b_out_last;
  logic [DW-1:0] b_out_data, b_cmp_a, b_cmp_b, b_cmp_y;

  assign s_cmp_y = ($signed(s_cmp_a) >= $signed(s_cmp_b)) ? s_cmp_a : s_cmp_b;
  assign b_cmp_y = ($signed(b_cmp_a) >= $signed(b_cmp_b)) ? b_cmp_a : b_cmp_b;

  maxpool2x2_sched #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .busy(s_busy), .done(s_done),
    .in_valid(in_valid & ~sel), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_last(s_out_last),
    .cmp_a(s_cmp_a), .cmp_b(s_cmp_b), .cmp_y(s_cmp_y)
  );

  maxpool2x2_sched #(.DATA_W(DW), .IMG_W(24), .IMG_H(24)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .busy(b_busy), .done(b_done),
    .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .cmp_a(b_cmp_a), .cmp_b(b_cmp_b), .cmp_y(b_cmp_y)
  );

  logic          m_busy, m_done, m_in_ready, m_out_valid, m_out_last;
  logic [DW-1:0] m_out_data;
  assign m_busy      = sel ? b_busy      : s_busy;
  assign m_done      = sel ? b_done      : s_done;
  assign m_in_ready  = sel ? b_in_ready  : s_in_ready;
  assign m_out_valid = sel ? b_out_valid : s_out_valid;
  assign m_out_last  = sel ? b_out_last  : s_out_last;
  assign m_out_data  = sel ? b_out_data  : s_out_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  logic signed [DW-1:0] px_q[$];
  logic signed [DW-1:0] exp_q[$];
  logic signed [DW-1:0] got_q[$];
  bit                   gotl_q[$];
  int cyc = 0, hs_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n && m_out_valid && out_ready) begin
      got_q.push_back(m_out_data);
      gotl_q.push_back(m_out_last);
      hs_cyc = cyc;
    end
    if (rst_n && m_done) done_cyc = cyc;
  end

  // Reference: max over each non-overlapping 2x2 window of the raster frame.
  task automatic ref_pool(input int w, input int h);
    logic signed [DW-1:0] m, v;
    exp_q.delete();
    for (int r = 0; r < h; r += 2) begin
      for (int c = 0; c < w; c += 2) begin
        m = px_q[r*w + c];
        v = px_q[r*w + c + 1];     if (v > m) m = v;
        v = px_q[(r+1)*w + c];     if (v > m) m = v;
        v = px_q[(r+1)*w + c + 1]; if (v > m) m = v;
        exp_q.push_back(m);
      end
    end
  endtask

  task automatic gen_frame(input int w, input int h, input bit narrow);
    px_q.delete();
    for (int i = 0; i < w*h; i++) begin
      if (narrow) px_q.push_back(DW'(int'($urandom_range(0, 3)) - 2));
      else        px_q.push_back(DW'($urandom));
    end
  endtask

  task automatic run_frame(input int w, input int h, input int vpct, input int rpct,
                           input bit do_start, input bit chain, input bit stall, input string nm);
    int idx, n, lim, k, stall_left, lastcnt;
    bit seen, fin, acc;
    idx = 0; n = w*h; lim = n*8 + 200; k = 0; stall_left = 0; seen = 0; fin = 0; lastcnt = 0;
    got_q.delete();
    gotl_q.delete();
    if (do_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    while (!fin && k < lim) begin
      in_valid = (idx < n) && ($urandom_range(0, 99) < vpct);
      in_data  = (idx < n) ? px_q[idx] : '0;
      if (stall && !seen && m_out_valid) begin
        seen = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(0, 99) < rpct);
      end
      @(negedge clk);
      if (stall && !out_ready) begin
        check({nm, "_stall_in_ready"}, m_in_ready, 0);
        check({nm, "_stall_hold"}, $signed(m_out_data), 5);
      end
      acc = in_valid && m_in_ready;
      if (m_done) begin
        fin = 1'b1;
        if (chain) start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) idx++;
      k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({nm, "_done_seen"}, fin, 1);
    check({nm, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({nm, "_data"}, got_q[i], exp_q[i]);
    foreach (gotl_q[i]) if (gotl_q[i]) lastcnt++;
    check({nm, "_last_count"}, lastcnt, 1);
    if (gotl_q.size() > 0) check({nm, "_last_pos"}, gotl_q[gotl_q.size()-1], 1);
    if (!chain) check({nm, "_idle_after"}, m_busy, 0);
  endtask

  typedef struct {
    string                name;
    logic signed [DW-1:0] px[16];
    logic signed [DW-1:0] ex[4];
  } vec_t;
  vec_t tbl[3];

  int  idx6, k6;
  bit  acc6;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel = 1'b0;

    tbl[0].name = "T1";
    tbl[1].name = "T2";
    tbl[2].name = "T4";
    for (int i = 0; i < 16; i++) begin
      tbl[0].px[i] = DW'(i);
      tbl[1].px[i] = DW'(-(i + 1));
      tbl[2].px[i] = 12'sh7FF;
    end
    tbl[2].px[0]  = 12'sh800;
    tbl[2].px[3]  = 12'sh800;
    tbl[2].px[9]  = 12'sh800;
    tbl[2].px[14] = 12'sh800;
    tbl[0].ex = '{12'sd5, 12'sd7, 12'sd13, 12'sd15};
    tbl[1].ex = '{-12'sd1, -12'sd3, -12'sd9, -12'sd11};
    tbl[2].ex = '{12'sh7FF, 12'sh7FF, 12'sh7FF, 12'sh7FF};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", s_busy, 0);
    check("reset_in_ready", s_in_ready, 0);
    check("reset_out_valid", s_out_valid, 0);
    check("reset_out_data", s_out_data, 0);
    check("reset_out_last", s_out_last, 0);
    check("reset_done", s_done, 0);
    check("reset_cmp_a", s_cmp_a, 0);
    check("reset_cmp_b", s_cmp_b, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 3; t++) begin
      px_q.delete();
      exp_q.delete();
      for (int i = 0; i < 16; i++) px_q.push_back(tbl[t].px[i]);
      for (int i = 0; i < 4; i++)  exp_q.push_back(tbl[t].ex[i]);
      run_frame(4, 4, 100, 100, 1'b1, 1'b0, 1'b0, tbl[t].name);
      if (t == 0) check("T1_done_lat", done_cyc - hs_cyc, 1);
      repeat (2) @(posedge clk);
      #1;
    end

    // Output stall: same frame as T1 with out_ready held low for 5 cycles.
    px_q.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) px_q.push_back(tbl[0].px[i]);
    for (int i = 0; i < 4; i++)  exp_q.push_back(tbl[0].ex[i]);
    run_frame(4, 4, 100, 100, 1'b1, 1'b0, 1'b1, "T3");

    for (int f = 0; f < 6; f++) begin
      gen_frame(4, 4, f[0]);
      ref_pool(4, 4);
      run_frame(4, 4, 60, 70, 1'b1, 1'b0, 1'b0, "RND4");
    end

    // Two 24x24 frames, the second started in the done cycle of the first.
    sel = 1'b1;
    @(posedge clk); #1;
    gen_frame(24, 24, 1'b0);
    ref_pool(24, 24);
    run_frame(24, 24, 80, 80, 1'b1, 1'b1, 1'b0, "T5a");
    check("T5_busy_chained", m_busy, 1);
    gen_frame(24, 24, 1'b1);
    ref_pool(24, 24);
    run_frame(24, 24, 100, 100, 1'b0, 1'b0, 1'b0, "T5b");

    // Async reset mid-frame (row 3) with a result held on the output.
    sel = 1'b0;
    @(posedge clk); #1;
    px_q.delete();
    for (int i = 0; i < 16; i++) px_q.push_back(tbl[0].px[i]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx6 = 0; k6 = 0;
    while (idx6 < 14 && k6 < 100) begin
      in_valid = 1'b1;
      in_data  = px_q[idx6];
      @(negedge clk);
      acc6 = m_in_ready;
      @(posedge clk); #1;
      if (acc6) idx6++;
      k6++;
    end
    check("T6_accepted", idx6, 14);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("T6_pre_valid", s_out_valid, 1);
    check("T6_pre_data", $signed(s_out_data), 13);
    #2 rst_n = 1'b0;
    #1;
    check("T6_busy", s_busy, 0);
    check("T6_in_ready", s_in_ready, 0);
    check("T6_out_valid", s_out_valid, 0);
    check("T6_out_data", s_out_data, 0);
    check("T6_out_last", s_out_last, 0);
    check("T6_done", s_done, 0);
    check("T6_cmp_a", s_cmp_a, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(tbl[0].ex[i]);
    run_frame(4, 4, 100, 100, 1'b1, 1'b0, 1'b0, "T6_rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
